// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the four sources and the round-robin mux-select arbiter.
// The arbiter takes the slave view; the sources (or a bench) drive Req through the master view.
interface mux_sel_arbiter_if;
  logic [3:0] Req;
  logic [3:0] Grant;
  logic [1:0] Sel;
  logic       Valid;
  logic       Preempt;

  modport master (output Req, input Grant, Sel, Valid, Preempt);
  modport slave  (input Req, output Grant, Sel, Valid, Preempt);
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the Sel/Grant of a shared mux_4_to_1; holds a grant until Req drops.
// Optional forced preemption after MAX_HOLD cycles is enabled by defining MUX_SEL_TIMEOUT_EN.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic              Clk,
  input logic              Reset,
  mux_sel_arbiter_if.slave bus
);

  if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_cfg_check
    $error("mux_sel_arbiter: need MAX_HOLD >= 2 and 2**CNT_W > MAX_HOLD");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q;
  logic [3:0] grant_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;
  logic       valid_q;

  logic [3:0] cand;
  logic [3:0] rot_req;
  logic [1:0] win_off;
  logic [1:0] win_idx;
  logic       win_found;
  logic       owner_req;
  logic       grant_en;
  logic       go_idle;

  // While busy the owner is masked out, so a preemption never re-selects it.
  assign cand      = (state_q == BUSY) ? (bus.Req & ~grant_q) : bus.Req;
  assign owner_req = bus.Req[sel_q];

  // rot_req[k] is the candidate k+1 places after the last grantee.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = cand[2'(ptr_q + 2'(gi + 1))];
  end

  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) win_off = 2'(k);
    end
  end

  assign win_found = |rot_req;
  assign win_idx   = ptr_q + win_off + 2'd1;

`ifdef MUX_SEL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q;
  logic             preempt_q;
  logic             preempt_en;

  assign preempt_en = (state_q == BUSY) && owner_req && (hold_cnt_q == HOLD_LAST) && win_found;
`else
  logic preempt_en;

  assign preempt_en = 1'b0;
`endif

  assign grant_en = win_found && ((state_q == IDLE) || !owner_req || preempt_en);
  assign go_idle  = (state_q == BUSY) && !owner_req && !win_found;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b11;
      valid_q <= 1'b0;
    end else if (grant_en) begin
      state_q <= BUSY;
      grant_q <= 4'b0001 << win_idx;
      sel_q   <= win_idx;
      ptr_q   <= win_idx;
      valid_q <= 1'b1;
    end else if (go_idle) begin
      // Sel keeps its last value so the mux output stays stable while idle.
      state_q <= IDLE;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
    end
  end

`ifdef MUX_SEL_TIMEOUT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= preempt_en;
      if (grant_en) begin
        hold_cnt_q <= '0;
      end else if (state_q == BUSY && hold_cnt_q != HOLD_LAST) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end

  assign bus.Preempt = preempt_q;
`else
  assign bus.Preempt = 1'b0;
`endif

  assign bus.Grant = grant_q;
  assign bus.Sel   = sel_q;
  assign bus.Valid = valid_q;

endmodule
